// File: rtl/fifo_rd_ctrl_if.sv
// Signal bundle between the FIFO read controller, the writer/memory side and the consumer.
// The master modport is the controller's view; the slave modport is the environment's view.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  empty;

    modport master (
        input  wr_ptr,
        input  mem_dout,
        input  m_ready,
        output rd_ptr,
        output mem_rd_en,
        output mem_rd_addr,
        output m_valid,
        output m_data,
        output empty
    );

    modport slave (
        output wr_ptr,
        output mem_dout,
        output m_ready,
        input  rd_ptr,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  m_valid,
        input  m_data,
        input  empty
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: turns a 1-cycle-latency memory read port into a
// first-word-fall-through valid/ready stream using a 2-entry output buffer.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_rd_ctrl_if.master bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_PTR = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [AW:0]           rd_ptr_q;
    logic [AW:0]           rd_ptr_d;
    logic                  inflight_q;
    logic                  inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q;
    logic [DATA_WIDTH-1:0] buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q;
    logic [DATA_WIDTH-1:0] buf1_d;

    logic [AW:0] pending_s;
    logic [1:0]  count_s;
    logic        pop_s;
    logic [2:0]  occ_now_s;
    logic [2:0]  occ_after_s;
    logic        rd_en_s;

    // Occupancy decode and fetch decision: a fetch is allowed only when the
    // buffer plus the word in flight, after this cycle's pop, leaves a free slot.
    always_comb begin
        case (state_q)
            EMPTY:   count_s = 2'd0;
            ONE:     count_s = 2'd1;
            TWO:     count_s = 2'd2;
            default: count_s = 2'd0;
        endcase
        pending_s   = bus.wr_ptr - rd_ptr_q;
        pop_s       = (state_q != EMPTY) && bus.m_ready;
        occ_now_s   = {1'b0, count_s} + {2'b00, inflight_q};
        occ_after_s = occ_now_s - {2'b00, pop_s};
        rd_en_s     = rst_n && (pending_s != {(AW + 1){1'b0}}) && (occ_after_s < 3'd2);
    end

    // Next-state logic for the fetch pointer, in-flight flag and output buffer.
    always_comb begin
        state_d    = state_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_en_s};
        inflight_d = rd_en_s;

        case (state_q)
            EMPTY: begin
                if (inflight_q) begin
                    buf0_d  = bus.mem_dout;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                case ({inflight_q, pop_s})
                    2'b10: begin
                        buf1_d  = bus.mem_dout;
                        state_d = TWO;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b11: begin
                        buf0_d  = bus.mem_dout;
                        state_d = ONE;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            TWO: begin
                // A fill without a pop cannot occur here: the fetch gate forbids it.
                if (pop_s) begin
                    buf0_d = buf1_q;
                    if (inflight_q) begin
                        buf1_d  = bus.mem_dout;
                        state_d = TWO;
                    end else begin
                        state_d = ONE;
                    end
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops buffered and in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rd_ptr_q   <= {(AW + 1){1'b0}};
            inflight_q <= 1'b0;
            buf0_q     <= {DATA_WIDTH{1'b0}};
            buf1_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    // Guards on writer behaviour and buffer occupancy.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (pending_s <= DEPTH_PTR)
                else $error("fifo_rd_ctrl: writer ran more than DEPTH words ahead");
            assert (occ_now_s <= 3'd2)
                else $error("fifo_rd_ctrl: buffer plus in-flight above two");
        end
    end

    assign bus.rd_ptr      = rd_ptr_q;
    assign bus.mem_rd_en   = rd_en_s;
    assign bus.mem_rd_addr = rd_ptr_q[AW-1:0];
    assign bus.m_valid     = (state_q != EMPTY);
    assign bus.m_data      = buf0_q;
    assign bus.empty       = (bus.wr_ptr == rd_ptr_q);
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: reset, single word, streaming, backpressure,
// reset mid-operation and pointer wrap, with hand-computed expectations.
module tb_fifo_rd_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];

    // Synchronous memory model: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_dout <= mem[bus.mem_rd_addr];
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_addr [4];
    int         nreads;

    initial begin
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        rst_n        = 1'b0;
        bus.wr_ptr   = 5'd5;
        bus.m_ready  = 1'b0;
        mem[0]       = 8'hA5;

        // Reset held for three cycles with a non-zero writer pointer
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin
                bus.wr_ptr = 5'd0;
            end
            #1;
            check("rst_rd_en",   bus.mem_rd_en, 32'd0);
            check("rst_m_valid", bus.m_valid,   32'd0);
            check("rst_rd_ptr",  bus.rd_ptr,    32'd0);
            check("rst_m_data",  bus.m_data,    32'd0);
            check("rst_empty",   bus.empty,     (c == 2) ? 32'd1 : 32'd0);
        end

        // Single word through, consumer ready
        tick();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("idle_rd_en", bus.mem_rd_en, 32'd0);
        check("idle_empty", bus.empty,     32'd1);
        tick();
        bus.wr_ptr = 5'd1;
        #1;
        check("one_c0_rd_en", bus.mem_rd_en,   32'd1);
        check("one_c0_addr",  bus.mem_rd_addr, 32'd0);
        check("one_c0_empty", bus.empty,       32'd0);
        tick(); #1;
        check("one_c1_rd_ptr",  bus.rd_ptr,    32'd1);
        check("one_c1_empty",   bus.empty,     32'd1);
        check("one_c1_m_valid", bus.m_valid,   32'd0);
        check("one_c1_rd_en",   bus.mem_rd_en, 32'd0);
        tick(); #1;
        check("one_c2_m_valid", bus.m_valid, 32'd1);
        check("one_c2_m_data",  bus.m_data,  32'hA5);
        tick(); #1;
        check("one_c3_m_valid", bus.m_valid, 32'd0);

        // Streaming 16 words, no bubbles
        for (int i = 0; i < 16; i++) begin
            mem[4'(i + 1)] = 8'(i);
        end
        tick();
        bus.wr_ptr = 5'd17;
        #1;
        check("str_rd_en", bus.mem_rd_en,   32'd1);
        check("str_addr",  bus.mem_rd_addr, 32'd1);
        tick(); #1;
        check("str_lat_m_valid", bus.m_valid, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            #1;
            check("str_m_valid", bus.m_valid, 32'd1);
            check("str_m_data",  bus.m_data,  32'(i));
            tick();
        end
        #1;
        check("str_end_m_valid", bus.m_valid, 32'd0);
        check("str_end_rd_ptr",  bus.rd_ptr,  32'd17);
        check("str_end_empty",   bus.empty,   32'd1);

        // Backpressure: five words, consumer stalled
        for (int i = 0; i < 5; i++) begin
            mem[4'(i + 1)] = 8'(8'h30 + i);
        end
        tick();
        bus.m_ready = 1'b0;
        bus.wr_ptr  = 5'd22;
        #1;
        nreads = 0;
        for (int c = 0; c < 6; c++) begin
            nreads += int'(bus.mem_rd_en);
            tick(); #1;
        end
        check("bp_reads",   32'(nreads),  32'd2);
        check("bp_rd_ptr",  bus.rd_ptr,   32'd19);
        check("bp_m_valid", bus.m_valid,  32'd1);
        check("bp_m_data",  bus.m_data,   32'h30);
        tick(); #1;
        check("bp_hold_m_data", bus.m_data,    32'h30);
        check("bp_hold_rd_en",  bus.mem_rd_en, 32'd0);
        tick();
        bus.m_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rel_m_valid", bus.m_valid, 32'd1);
            check("bp_rel_m_data",  bus.m_data,  32'(8'h30 + i));
            tick(); #1;
        end
        check("bp_end_m_valid", bus.m_valid, 32'd0);
        check("bp_end_rd_ptr",  bus.rd_ptr,  32'd22);
        check("bp_end_empty",   bus.empty,   32'd1);

        // Reset with one word buffered and one in flight
        mem[6] = 8'hE0;
        mem[7] = 8'hE1;
        mem[8] = 8'hE2;
        tick();
        bus.m_ready = 1'b0;
        bus.wr_ptr  = 5'd25;
        #1;
        check("mid_c0_rd_en", bus.mem_rd_en,   32'd1);
        check("mid_c0_addr",  bus.mem_rd_addr, 32'd6);
        tick(); #1;
        check("mid_c1_rd_en",   bus.mem_rd_en, 32'd1);
        check("mid_c1_m_valid", bus.m_valid,   32'd0);
        tick(); #1;
        check("mid_c2_m_valid", bus.m_valid,   32'd1);
        check("mid_c2_m_data",  bus.m_data,    32'hE0);
        check("mid_c2_rd_ptr",  bus.rd_ptr,    32'd24);
        rst_n      = 1'b0;
        bus.wr_ptr = 5'd0;
        #1;
        check("mid_rst_rd_en", bus.mem_rd_en, 32'd0);
        check("mid_rst_empty", bus.empty,     32'd0);
        tick();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("mid_post_m_valid", bus.m_valid,   32'd0);
        check("mid_post_rd_ptr",  bus.rd_ptr,    32'd0);
        check("mid_post_m_data",  bus.m_data,    32'd0);
        check("mid_post_rd_en",   bus.mem_rd_en, 32'd0);
        check("mid_post_empty",   bus.empty,     32'd1);
        tick(); #1;
        check("mid_stale_m_valid", bus.m_valid, 32'd0);

        // Advance both pointers to 14, then wrap across the end of the memory
        for (int i = 0; i < 14; i++) begin
            mem[4'(i)] = 8'(8'h40 + i);
        end
        tick();
        bus.wr_ptr = 5'd14;
        #1;
        for (int c = 0; c < 18; c++) begin
            tick();
        end
        #1;
        check("wrap_pre_rd_ptr",  bus.rd_ptr,  32'd14);
        check("wrap_pre_empty",   bus.empty,   32'd1);
        check("wrap_pre_m_valid", bus.m_valid, 32'd0);
        mem[14] = 8'hC0;
        mem[15] = 8'hC1;
        mem[0]  = 8'hC2;
        mem[1]  = 8'hC3;
        tick();
        bus.wr_ptr = 5'b10010;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                check("wrap_rd_en", bus.mem_rd_en,   32'd1);
                check("wrap_addr",  bus.mem_rd_addr, 32'(exp_addr[i]));
            end
            if (i >= 2) begin
                check("wrap_m_valid", bus.m_valid, 32'd1);
                check("wrap_m_data",  bus.m_data,  32'(8'hC0 + i - 2));
            end
            tick(); #1;
        end
        check("wrap_end_m_valid", bus.m_valid,   32'd0);
        check("wrap_end_rd_ptr",  bus.rd_ptr,    32'b10010);
        check("wrap_end_empty",   bus.empty,     32'd1);
        check("wrap_end_rd_en",   bus.mem_rd_en, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
